// File: rtl/uart_pkg.sv
// Shared encodings and widths for the UART transmit scheduler.
// Frame slots run 0..FRAME_LAST; slot FRAME_LAST returns the line to idle.
package uart_pkg;

    localparam int WORD_W    = 16;
    localparam int BIT_CNT_W = 5;
    localparam int SUB_CNT_W = 10;

    localparam logic [BIT_CNT_W-1:0] FRAME_LAST = 5'd21;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_SEND   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin select: first valid requester strictly after ptr,
// wrapping cyclically, so the last winner gets lowest priority next time.
module uart_rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   sel,
    output logic               any
);

    logic [PTR_W-1:0] cand;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        sel  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = wrap_idx(ptr, i);
            if (!any && req_valid[cand]) begin
                any = 1'b1;
                sel = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one two-byte UART transmitter between NUM_REQ word producers:
// owns baud timing, round-robin arbitration, word latching and gap insertion.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  CLKS_PER_BIT = 100,
    parameter int  SAMPLE_PT    = 49,
    parameter int  GAP_SLOTS    = 1,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [WORD_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [WORD_W-1:0]         tx_data,
    output logic                      tx_enable,
    output logic [BIT_CNT_W-1:0]      bit_cnt,
    output logic [SUB_CNT_W-1:0]      sub_cnt,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      frame_done
);

    localparam logic [SUB_CNT_W-1:0] SUB_LAST = SUB_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [SUB_CNT_W-1:0] SUB_TICK = SUB_CNT_W'(SAMPLE_PT);
    localparam logic [3:0]           GAP_LAST = (GAP_SLOTS == 0) ? 4'd0 : 4'(GAP_SLOTS - 1);
    localparam bit                   NO_GAP   = (GAP_SLOTS == 0);

    state_t             state, state_next;
    logic [ID_W-1:0]    ptr, sel;
    logic               any;
    logic [3:0]         gap_cnt;
    logic               tick, wrap;
    logic               accept, frame_end, gap_end;
    logic [NUM_REQ-1:0] sel_onehot;

    // tick is the transmitter's sampling instant; wrap is where bit_cnt moves,
    // half a bit away, so every tick sees a settled slot number.
    assign tick       = (sub_cnt == SUB_TICK);
    assign wrap       = (sub_cnt == SUB_LAST);
    assign sel_onehot = NUM_REQ'(1) << sel;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr),
        .sel       (sel),
        .any       (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        frame_end  = 1'b0;
        gap_end    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    accept     = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (tick) state_next = ST_SEND;
            end
            ST_SEND: begin
                if (tick && bit_cnt == FRAME_LAST) begin
                    frame_end  = 1'b1;
                    gap_end    = NO_GAP;
                    state_next = NO_GAP ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick && gap_cnt == GAP_LAST) begin
                    gap_end    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            req_ready  <= '0;
            tx_data    <= '0;
            tx_enable  <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= '0;
            ptr        <= ID_W'(NUM_REQ - 1);
            frame_done <= 1'b0;
        end else begin
            sub_cnt    <= wrap ? '0 : sub_cnt + 1'b1;
            req_ready  <= accept ? sel_onehot : '0;
            frame_done <= frame_end;

            if (accept) begin
                tx_data  <= req_data[int'(sel)*WORD_W +: WORD_W];
                grant_id <= sel;
                ptr      <= sel;
            end

            if (accept)                          tx_enable <= 1'b1;
            else if (state == ST_LAUNCH && tick) tx_enable <= 1'b0;

            if (accept)       busy <= 1'b1;
            else if (gap_end) busy <= 1'b0;

            if (state != ST_SEND || frame_end) bit_cnt <= '0;
            else if (wrap)                     bit_cnt <= bit_cnt + 1'b1;

            if (state != ST_GAP || gap_end) gap_cnt <= '0;
            else if (tick)                  gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched with a frame-level timing/arbitration model;
// two small extra instances measure launch spacing for GAP_SLOTS 0 and 3.
module tb_uart_tx_sched;

    localparam int N    = 4;
    localparam int C    = 100;
    localparam int SP   = 49;
    localparam int G    = 1;
    localparam int LAST = 21;
    localparam int BUSY_FALL = (LAST + G) * C + 1;
    localparam int GC   = 10;
    localparam int GSP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [16*N-1:0] req_data  = '0;
    logic [N-1:0]    req_ready;
    logic [15:0]     tx_data;
    logic            tx_enable, busy, frame_done;
    logic [4:0]      bit_cnt;
    logic [9:0]      sub_cnt;
    logic [1:0]      grant_id;

    uart_tx_sched #(.NUM_REQ(N), .CLKS_PER_BIT(C), .SAMPLE_PT(SP), .GAP_SLOTS(G)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_data(tx_data), .tx_enable(tx_enable),
        .bit_cnt(bit_cnt), .sub_cnt(sub_cnt), .busy(busy),
        .grant_id(grant_id), .frame_done(frame_done)
    );

    logic [N-1:0]    g_valid = 4'b0001;
    logic [16*N-1:0] g_data  = 64'h1234;
    logic [N-1:0]    g0_ready, g3_ready;
    logic [15:0]     g0_tx_data, g3_tx_data;
    logic            g0_tx_enable, g3_tx_enable, g0_busy, g3_busy, g0_fd, g3_fd;
    logic [4:0]      g0_bit_cnt, g3_bit_cnt;
    logic [9:0]      g0_sub_cnt, g3_sub_cnt;
    logic [1:0]      g0_grant, g3_grant;

    uart_tx_sched #(.NUM_REQ(N), .CLKS_PER_BIT(GC), .SAMPLE_PT(GSP), .GAP_SLOTS(0)) dut_g0 (
        .clk(clk), .rst(rst), .req_valid(g_valid), .req_data(g_data),
        .req_ready(g0_ready), .tx_data(g0_tx_data), .tx_enable(g0_tx_enable),
        .bit_cnt(g0_bit_cnt), .sub_cnt(g0_sub_cnt), .busy(g0_busy),
        .grant_id(g0_grant), .frame_done(g0_fd)
    );

    uart_tx_sched #(.NUM_REQ(N), .CLKS_PER_BIT(GC), .SAMPLE_PT(GSP), .GAP_SLOTS(3)) dut_g3 (
        .clk(clk), .rst(rst), .req_valid(g_valid), .req_data(g_data),
        .req_ready(g3_ready), .tx_data(g3_tx_data), .tx_enable(g3_tx_enable),
        .bit_cnt(g3_bit_cnt), .sub_cnt(g3_sub_cnt), .busy(g3_busy),
        .grant_id(g3_grant), .frame_done(g3_fd)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Producer queues: each requester presents its queue head while enabled.
    logic [15:0] src_mem[N][16];
    int          src_head[N];
    int          src_tail[N];
    logic [N-1:0] en = '1;

    // Scoreboard / model state.
    logic [15:0] exp_q[$];
    int          grant_log[$];
    bit          in_frame = 1'b0;
    int          launch_cyc = 0;
    int          mptr = N - 1;
    int          cyc = 0;
    int          n_since = 0;
    int          done_model = 0;
    int          fd_seen = 0;
    int          rdy_cnt[N];
    logic        last_busy = 1'b0;
    logic [15:0] dec = '0;

    task automatic push(input int i, input logic [15:0] w);
        src_mem[i][src_tail[i] % 16] = w;
        src_tail[i]++;
    endtask

    function automatic bit pending_en();
        for (int i = 0; i < N; i++)
            if (en[i] && src_tail[i] != src_head[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (p + i) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Line level seen by the receiver during slot k of the frame.
    function automatic logic line_bit(input int k, input logic [15:0] d);
        if (k >= 1 && k <= 8)   return d[k-1];
        if (k >= 12 && k <= 19) return d[k-4];
        if (k == 11)            return 1'b0;
        return 1'b1;
    endfunction

    // Monitor + producer driver, one process so sampling precedes re-driving.
    initial begin
        int r, w, d, k, ph, sub_e;
        logic lb;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
            rdy_cnt[i]  = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                n_since   = 0;
                in_frame  = 1'b0;
                mptr      = N - 1;
                last_busy = 1'b0;
                exp_q.delete();
            end else begin
                n_since++;
                sub_e = n_since % C;
                if (sub_e == SP || sub_e == C - 1) check_eq("sub_cnt", sub_cnt, sub_e);
                if (frame_done) fd_seen++;
                if (req_ready != '0) begin
                    r = -1;
                    for (int i = N - 1; i >= 0; i--) if (req_ready[i]) r = i;
                    w = rr_pick(req_valid, mptr);
                    check_eq("ready_onehot", $countones(req_ready), 1);
                    check_eq("ready_only_when_idle", {in_frame, last_busy}, 0);
                    check_eq("grant_sel", r, w);
                    check_eq("grant_id", grant_id, w);
                    if (w >= 0) begin
                        check_eq("tx_data_latch", tx_data, src_mem[w][src_head[w] % 16]);
                        exp_q.push_back(src_mem[w][src_head[w] % 16]);
                        grant_log.push_back(w);
                        mptr = w;
                    end
                    check_eq("accept_busy", busy, 1);
                    check_eq("accept_enable", tx_enable, 1);
                    check_eq("accept_bit_cnt", bit_cnt, 0);
                    in_frame   = 1'b1;
                    launch_cyc = cyc + ((SP - sub_e + C) % C);
                    dec        = '0;
                end
                if (in_frame && cyc >= launch_cyc) begin
                    d  = cyc - launch_cyc;
                    k  = d / C;
                    ph = d % C;
                    if (d == 0) check_eq("launch_enable", tx_enable, 1);
                    if (d == 1) check_eq("enable_drop", tx_enable, 0);
                    if (ph == 0 && k >= 1 && k <= LAST) begin
                        check_eq("bit_cnt_at_tick", bit_cnt, k);
                        lb = line_bit(k, tx_data);
                        if (k >= 1 && k <= 8)   dec[k-1] = lb;
                        if (k >= 12 && k <= 19) dec[k-4] = lb;
                    end
                    if (ph == 1 && k >= 1 && k < LAST) check_eq("bit_cnt_stable", bit_cnt, k);
                    if (d == LAST * C || d == LAST * C + 2) check_eq("frame_done_low", frame_done, 0);
                    if (d == LAST * C + 1) begin
                        check_eq("frame_done_pulse", frame_done, 1);
                        if (exp_q.size() > 0) check_eq("decoded_word", dec, exp_q.pop_front());
                        else check_eq("scoreboard_empty", 1, 0);
                        done_model++;
                    end
                    if (d == BUSY_FALL - 1) begin
                        check_eq("busy_before_gap_end", busy, 1);
                        check_eq("bit_cnt_after_frame", bit_cnt, 0);
                    end
                    if (d == BUSY_FALL) begin
                        check_eq("busy_fall", busy, 0);
                        in_frame = 1'b0;
                    end
                end
                for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
                last_busy = busy;
            end
            for (int i = 0; i < N; i++) begin
                if (!rst && req_ready[i] && src_tail[i] != src_head[i]) src_head[i]++;
                req_valid[i]         = en[i] && (src_tail[i] != src_head[i]);
                req_data[16*i +: 16] = src_mem[i][src_head[i] % 16];
            end
        end
    end

    // Launch-to-launch spacing: (21 + 1 + GAP_SLOTS) bit periods.
    int g0_n = 0;
    int g3_n = 0;
    initial begin
        int c0, c3, l0, l3;
        c0 = 0; c3 = 0; l0 = -1; l3 = -1;
        forever begin
            @(negedge clk);
            c0++; c3++;
            if (rst) begin
                l0 = -1;
                l3 = -1;
            end else begin
                if (g0_tx_enable && g0_sub_cnt == 10'(GSP)) begin
                    if (l0 >= 0 && g0_n < 5) begin
                        check_eq("gap0_spacing", c0 - l0, 22 * GC);
                        g0_n++;
                    end
                    l0 = c0;
                end
                if (g3_tx_enable && g3_sub_cnt == 10'(GSP)) begin
                    if (l3 >= 0 && g3_n < 5) begin
                        check_eq("gap3_spacing", c3 - l3, 25 * GC);
                        g3_n++;
                    end
                    l3 = c3;
                end
            end
        end
    end

    task automatic wait_idle(input int maxc);
        int c;
        c = 0;
        while ((pending_en() || in_frame) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check_eq("idle_reached", (c < maxc), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int base2, c, m;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_tx_enable", tx_enable, 0);
        check_eq("rst_bit_cnt", bit_cnt, 0);
        check_eq("rst_sub_cnt", sub_cnt, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant_id", grant_id, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_req_ready", req_ready, 0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Single word
        push(0, 16'hA55A);
        wait_idle(6000);
        check_eq("single_frames", done_model, 1);
        check_eq("single_grant", grant_log[grant_log.size()-1], 0);

        // Round robin from a fresh pointer, all four valid at once
        do_reset();
        grant_log.delete();
        push(0, 16'h1111); push(1, 16'h2222); push(2, 16'h3333); push(3, 16'h4444);
        push(0, 16'h1111);
        wait_idle(15000);
        check_eq("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check_eq("rr_order", grant_log[i], i % 4);

        // Pointer to 1, then requesters 1 and 3 contend
        push(1, 16'h0B01);
        wait_idle(6000);
        base2 = rdy_cnt[2];
        grant_log.delete();
        push(1, 16'h0B0B); push(3, 16'h0D0D);
        wait_idle(10000);
        check_eq("skip_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check_eq("skip_first", grant_log[0], 3);
            check_eq("skip_second", grant_log[1], 1);
        end

        // Requester 2 raises valid during a busy frame and drops it again
        en[2] = 1'b0;
        push(2, 16'h2BAD);
        push(0, 16'h0F0F);
        repeat (20) @(negedge clk);
        en[2] = 1'b1;
        repeat (300) @(negedge clk);
        en[2] = 1'b0;
        wait_idle(6000);
        check_eq("dropped_req_no_ready", rdy_cnt[2], base2);
        en[2] = 1'b1;
        wait_idle(6000);
        check_eq("drained_req_ready", rdy_cnt[2], base2 + 1);

        // Reset mid-frame at slot 13
        push(1, 16'hC3C3);
        c = 0;
        while (bit_cnt != 5'd13 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check_eq("reach_slot13", (c < 5000), 1);
        push(2, 16'h5AA5);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_tx_data", tx_data, 0);
        check_eq("midrst_tx_enable", tx_enable, 0);
        check_eq("midrst_bit_cnt", bit_cnt, 0);
        check_eq("midrst_sub_cnt", sub_cnt, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_grant_id", grant_id, 0);
        check_eq("midrst_frame_done", frame_done, 0);
        check_eq("midrst_req_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        wait_idle(6000);
        check_eq("post_rst_grant", grant_log[grant_log.size()-1], 2);

        // Random traffic
        for (int rnd = 0; rnd < 5; rnd++) begin
            m = $urandom_range(1, 2);
            for (int j = 0; j < m; j++) push($urandom_range(0, N - 1), 16'($urandom));
            repeat ($urandom_range(0, 150)) @(negedge clk);
            wait_idle(12000);
        end

        check_eq("frame_done_total", fd_seen, done_model);
        check_eq("scoreboard_drained", exp_q.size(), 0);
        check_eq("gap0_measured", g0_n, 5);
        check_eq("gap3_measured", g3_n, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
